// File: rtl/traffic_scheduler_if.sv
// Game-flow control / lane-strobe bundle between the frog/collision logic and the scheduler.
// Latency: n/a (wires only).
// Backpressure: none; all signals are pulses or levels, no handshake.
//
// Ports (scheduler view, modport slave):
//   start, frog_hit, frog_home        in   game-event pulses
//   level[3:0], lives[1:0], state[2:0] out  game status
//   lane_step[5:0]                    out  per-lane one-cycle move strobes (bit 0 = top lane)
//   cars_reset, game_over             out  car re-home hold, game-over flag
interface traffic_scheduler_if;
    logic       start;
    logic       frog_hit;
    logic       frog_home;
    logic [3:0] level;
    logic [1:0] lives;
    logic [2:0] state;
    logic [5:0] lane_step;
    logic       cars_reset;
    logic       game_over;

    // Frog/collision side: raises events, observes game status.
    modport master (
        output start, frog_hit, frog_home,
        input  level, lives, state, lane_step, cars_reset, game_over
    );

    // Scheduler side.
    modport slave (
        input  start, frog_hit, frog_home,
        output level, lives, state, lane_step, cars_reset, game_over
    );
endinterface

// File: rtl/traffic_scheduler.sv
// Game-flow FSM (idle/play/freeze/clear/over) plus level-scaled per-lane car move strobes.
// Latency: all outputs registered; an input event is reflected in the outputs one cycle later.
// Backpressure: none; strobes are fire-and-forget, events outside their honoured states are dropped.
//
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high reset
//   bus    traffic_scheduler_if.slave (start/frog_hit/frog_home in; level/lives/state/
//          lane_step/cars_reset/game_over out)
module traffic_scheduler #(
    parameter logic [23:0] BASE_PERIOD   = 24'd50000,
    parameter logic [23:0] LEVEL_STEP    = 24'd5000,
    parameter logic [23:0] MIN_PERIOD    = 24'd10000,
    parameter logic [23:0] LANE_MULT     = 24'h242321,
    parameter logic [3:0]  MAX_LEVEL     = 4'd9,
    parameter logic [1:0]  LIVES         = 2'd3,
    parameter logic [23:0] FREEZE_CYCLES = 24'd25000000,
    parameter logic [23:0] CLEAR_CYCLES  = 24'd12500000
) (
    input  logic                clk,
    input  logic                reset,
    traffic_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PLAY   = 3'd1,
        S_FREEZE = 3'd2,
        S_CLEAR  = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t      state_q, state_n;
    logic [3:0]  level_q, level_n;
    logic [1:0]  lives_q, lives_n;

    logic [23:0] pre_cnt;
    logic [23:0] tmr;
    logic [3:0]  lane_cnt [6];
    logic [23:0] level_off;
    logic [23:0] period;
    logic        base_tick;
    logic [5:0]  lane_wrap;
    logic        enter_play;
    logic        stay_play;

    logic [5:0]  lane_step_q;
    logic        cars_reset_q;
    logic        game_over_q;

    // Prescaler period for the current level, floored at MIN_PERIOD. Level only
    // changes on the way out of PLAY, so the period is stable for a whole PLAY stint.
    always_comb begin
        level_off = {20'd0, level_q - 4'd1} * LEVEL_STEP;
        if (BASE_PERIOD < MIN_PERIOD + level_off) begin
            period = MIN_PERIOD;
        end else begin
            period = BASE_PERIOD - level_off;
        end
    end

    assign base_tick = (state_q == S_PLAY) && (pre_cnt == period - 24'd1);

    always_comb begin
        lane_wrap = '0;
        for (int i = 0; i < 6; i++) begin
            lane_wrap[i] = base_tick && (lane_cnt[i] == LANE_MULT[4*i +: 4] - 4'd1);
        end
    end

    // Next-state / next-status logic.
    always_comb begin
        state_n = state_q;
        level_n = level_q;
        lives_n = lives_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    state_n = S_PLAY;
                    level_n = 4'd1;
                    lives_n = LIVES;
                end
            end
            S_PLAY: begin
                // A hit wins over a simultaneous home arrival.
                if (bus.frog_hit) begin
                    state_n = S_FREEZE;
                    lives_n = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                end else if (bus.frog_home) begin
                    state_n = S_CLEAR;
                    level_n = (level_q >= MAX_LEVEL) ? MAX_LEVEL : level_q + 4'd1;
                end
            end
            S_FREEZE: begin
                if (tmr == FREEZE_CYCLES - 24'd1) begin
                    state_n = (lives_q == 2'd0) ? S_OVER : S_PLAY;
                end
            end
            S_CLEAR: begin
                if (tmr == CLEAR_CYCLES - 24'd1) begin
                    state_n = S_PLAY;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            level_q <= 4'd1;
            lives_q <= LIVES;
        end else begin
            state_q <= state_n;
            level_q <= level_n;
            lives_q <= lives_n;
        end
    end

    assign enter_play = (state_n == S_PLAY) && (state_q != S_PLAY);
    // Strobes are only emitted when the next cycle is still PLAY, so a wrap coinciding
    // with a hit/home never leaks a strobe into FREEZE/CLEAR.
    assign stay_play  = (state_n == S_PLAY) && (state_q == S_PLAY);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt      <= '0;
            tmr          <= '0;
            lane_step_q  <= '0;
            cars_reset_q <= 1'b1;
            game_over_q  <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                lane_cnt[i] <= '0;
            end
        end else begin
            // Counters restart on every PLAY entry and are held everywhere else.
            if (enter_play) begin
                pre_cnt <= '0;
                for (int i = 0; i < 6; i++) begin
                    lane_cnt[i] <= '0;
                end
            end else if (state_q == S_PLAY) begin
                pre_cnt <= base_tick ? 24'd0 : pre_cnt + 24'd1;
                for (int i = 0; i < 6; i++) begin
                    if (base_tick) begin
                        lane_cnt[i] <= lane_wrap[i] ? 4'd0 : lane_cnt[i] + 4'd1;
                    end
                end
            end

            // Dwell timer shared by FREEZE and CLEAR; zero on entry to any state.
            if (state_n != state_q) begin
                tmr <= '0;
            end else if (state_q == S_FREEZE || state_q == S_CLEAR) begin
                tmr <= tmr + 24'd1;
            end else begin
                tmr <= '0;
            end

            lane_step_q  <= stay_play ? lane_wrap : 6'd0;
            cars_reset_q <= (state_n == S_IDLE) || (state_n == S_CLEAR);
            game_over_q  <= (state_n == S_OVER);
        end
    end

    assign bus.state      = state_q;
    assign bus.level      = level_q;
    assign bus.lives      = lives_q;
    assign bus.lane_step  = lane_step_q;
    assign bus.cars_reset = cars_reset_q;
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_traffic_scheduler.sv
// Bench for traffic_scheduler: directed game scenarios with a cycle-level reference model.
// Latency: model predicts registered outputs one cycle after each input edge.
// Backpressure: none.
module tb_traffic_scheduler;

    logic clk;
    logic reset;
    logic chk_en;
    int   checks;
    int   errors;

    traffic_scheduler_if bus();

    traffic_scheduler #(
        .BASE_PERIOD  (24'd10),
        .LEVEL_STEP   (24'd2),
        .MIN_PERIOD   (24'd4),
        .LANE_MULT    (24'h242321),
        .MAX_LEVEL    (4'd9),
        .LIVES        (2'd3),
        .FREEZE_CYCLES(24'd5),
        .CLEAR_CYCLES (24'd3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    int mult [6] = '{1, 2, 3, 2, 4, 2};
    int m_state = 0;
    int m_level = 1;
    int m_lives = 3;
    int m_age   = 0;   // cycles since PLAY entry
    int m_cnt   = 0;   // cycles already spent in FREEZE/CLEAR

    function automatic int period(input int lvl);
        int p;
        p = 10 - (lvl - 1) * 2;
        if (10 < 4 + (lvl - 1) * 2) p = 4;
        return p;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_state = 0; m_level = 1; m_lives = 3; m_age = 0; m_cnt = 0;
        end else begin
            case (m_state)
                0, 4: if (bus.start) begin
                    m_state = 1; m_level = 1; m_lives = 3; m_age = 0;
                end
                1: begin
                    if (bus.frog_hit) begin
                        m_state = 2; m_lives = (m_lives == 0) ? 0 : m_lives - 1; m_cnt = 0;
                    end else if (bus.frog_home) begin
                        m_state = 3; m_level = (m_level >= 9) ? 9 : m_level + 1; m_cnt = 0;
                    end else begin
                        m_age++;
                    end
                end
                2: begin
                    if (m_cnt + 1 == 5) begin
                        m_state = (m_lives == 0) ? 4 : 1; m_age = 0;
                    end else m_cnt++;
                end
                3: begin
                    if (m_cnt + 1 == 3) begin
                        m_state = 1; m_age = 0;
                    end else m_cnt++;
                end
                default: m_state = 0;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [5:0] exp_ls;
            exp_ls = '0;
            if (m_state == 1 && m_age > 0) begin
                for (int i = 0; i < 6; i++) begin
                    if (m_age % (period(m_level) * mult[i]) == 0) exp_ls[i] = 1'b1;
                end
            end
            checks++;
            if (int'(bus.state) != m_state || int'(bus.level) != m_level ||
                int'(bus.lives) != m_lives || bus.lane_step != exp_ls ||
                bus.cars_reset != (m_state == 0 || m_state == 3) ||
                bus.game_over != (m_state == 4)) begin
                errors++;
                $display("FAIL model_cmp t=%0t got st=%0d lv=%0d li=%0d ls=%b cr=%b go=%b exp st=%0d lv=%0d li=%0d ls=%b",
                         $time, bus.state, bus.level, bus.lives, bus.lane_step, bus.cars_reset,
                         bus.game_over, m_state, m_level, m_lives, exp_ls);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic pulse(input logic s, input logic h, input logic m);
        bus.start = s; bus.frog_hit = h; bus.frog_home = m;
        @(negedge clk);
        bus.start = 1'b0; bus.frog_hit = 1'b0; bus.frog_home = 1'b0;
    endtask

    // Counts cycles spent in state st (starting at the current negedge), bounded.
    task automatic count_state(input int st, output int n);
        n = 0;
        while (int'(bus.state) == st && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Runs ncyc cycles of PLAY from age 0 and records the age of first pulses.
    task automatic measure(input int ncyc, output int f0, output int s0, output int f2, output int f4);
        int age;
        age = 0; f0 = -1; s0 = -1; f2 = -1; f4 = -1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            age++;
            if (bus.lane_step[0]) begin
                if (f0 < 0) f0 = age; else if (s0 < 0) s0 = age;
            end
            if (bus.lane_step[2] && f2 < 0) f2 = age;
            if (bus.lane_step[4] && f4 < 0) f4 = age;
        end
    endtask

    task automatic clear_level();
        int n;
        pulse(1'b0, 1'b0, 1'b1);
        count_state(3, n);
        chk("clear_dwell", n, 3);
    endtask

    initial begin
        int n, f0, s0, f2, f4;
        checks = 0; errors = 0; chk_en = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0; bus.frog_hit = 1'b0; bus.frog_home = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // 1: reset values, start, lane periods at level 1 (P=10)
        chk("rst_state", int'(bus.state), 0);
        chk("rst_level", int'(bus.level), 1);
        chk("rst_lives", int'(bus.lives), 3);
        chk("rst_cars_reset", int'(bus.cars_reset), 1);
        chk("rst_lane_step", int'(bus.lane_step), 0);
        chk("rst_game_over", int'(bus.game_over), 0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("start_play", int'(bus.state), 1);
        chk("start_cars_reset", int'(bus.cars_reset), 0);
        measure(45, f0, s0, f2, f4);
        chk("l1_lane0_first", f0, 10);
        chk("l1_lane0_second", s0, 20);
        chk("l1_lane2_first", f2, 30);
        chk("l1_lane4_first", f4, 40);
        pulse(1'b1, 1'b0, 1'b0);
        chk("start_ignored_play", int'(bus.state), 1);

        // 2: hit -> freeze for 5 cycles
        pulse(1'b0, 1'b1, 1'b0);
        chk("hit_state", int'(bus.state), 2);
        chk("hit_lives", int'(bus.lives), 2);
        chk("hit_lane_step", int'(bus.lane_step), 0);
        chk("hit_cars_reset", int'(bus.cars_reset), 0);
        count_state(2, n);
        chk("freeze_dwell", n, 5);
        chk("freeze_exit_state", int'(bus.state), 1);

        // 3: home at level 1 -> clear 3 cycles, then P=8
        pulse(1'b0, 1'b0, 1'b1);
        chk("home_state", int'(bus.state), 3);
        chk("home_level", int'(bus.level), 2);
        chk("home_cars_reset", int'(bus.cars_reset), 1);
        count_state(3, n);
        chk("clear_dwell_l2", n, 3);
        measure(20, f0, s0, f2, f4);
        chk("l2_lane0_first", f0, 8);
        chk("l2_lane0_second", s0, 16);

        // 4: level 4 -> P=4, level 5 floor P=4, saturation at 9
        clear_level();
        clear_level();
        chk("level4", int'(bus.level), 4);
        measure(10, f0, s0, f2, f4);
        chk("l4_lane0_first", f0, 4);
        chk("l4_lane0_second", s0, 8);
        clear_level();
        measure(10, f0, s0, f2, f4);
        chk("l5_lane0_first", f0, 4);
        for (int k = 0; k < 10; k++) clear_level();
        chk("level_sat", int'(bus.level), 9);

        // 5: remaining lives lost -> OVER, restart
        pulse(1'b0, 1'b1, 1'b0);
        count_state(2, n);
        pulse(1'b0, 1'b1, 1'b0);
        chk("last_hit_lives", int'(bus.lives), 0);
        count_state(2, n);
        chk("over_state", int'(bus.state), 4);
        chk("over_game_over", int'(bus.game_over), 1);
        chk("over_lane_step", int'(bus.lane_step), 0);
        pulse(1'b0, 1'b1, 1'b1);
        chk("over_ignores_events", int'(bus.state), 4);
        pulse(1'b1, 1'b0, 1'b0);
        chk("restart_state", int'(bus.state), 1);
        chk("restart_level", int'(bus.level), 1);
        chk("restart_lives", int'(bus.lives), 3);
        chk("restart_game_over", int'(bus.game_over), 0);

        // 6: simultaneous hit+home, then reset in FREEZE
        repeat (3) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b1);
        chk("both_state", int'(bus.state), 2);
        chk("both_level", int'(bus.level), 1);
        chk("both_lives", int'(bus.lives), 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_state", int'(bus.state), 0);
        chk("midrst_cars_reset", int'(bus.cars_reset), 1);
        chk("midrst_lives", int'(bus.lives), 3);
        chk("midrst_level", int'(bus.level), 1);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
